// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the loader/DMA (port 1).
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise port 0 has strict priority.
module dmem_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              CEN,
  output logic              WEN,
  output logic              OEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] Data2Mem,
  input  logic [DATA_W-1:0] ReadDataMem
);

  localparam int CNT_W = $clog2(READ_LAT + 1);

`ifdef DMEM_ARB_RR_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic              cap_we;
  logic              cap_port;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              last_grant;
  logic              pick;

  // Winner selection; under contention the policy bit decides between
  // fixed priority and alternating away from the previous winner.
  always_comb begin
    pick = req1;
    if (req0 && req1) begin
      pick = RR_EN ? ~last_grant : 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap_we     <= 1'b0;
      cap_port   <= 1'b0;
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cnt        <= '0;
      rdata      <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            cap_port   <= pick;
            cap_we     <= pick ? we1 : we0;
            cap_addr   <= pick ? addr1 : addr0;
            cap_wdata  <= pick ? wdata1 : wdata0;
            last_grant <= pick;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (cap_we) begin
            state <= IDLE;
          end else begin
            cnt   <= CNT_W'(READ_LAT);
            state <= WAIT;
          end
        end
        WAIT: begin
          // The memory output is captured on the edge closing the final wait cycle.
          if (cnt == CNT_W'(1)) begin
            rdata <= ReadDataMem;
            state <= RESP;
          end
          cnt <= cnt - CNT_W'(1);
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes are decoded from the state; address and write data hold the last capture.
  assign busy     = (state != IDLE);
  assign CEN      = !((state == ISSUE) || (state == WAIT));
  assign WEN      = !((state == ISSUE) && cap_we);
  assign OEN      = !(((state == ISSUE) && !cap_we) || (state == WAIT));
  assign A        = cap_addr;
  assign Data2Mem = cap_wdata;
  assign gnt0     = (state == ISSUE) && !cap_port;
  assign gnt1     = (state == ISSUE) && cap_port;
  assign rvalid0  = (state == RESP) && !cap_port;
  assign rvalid1  = (state == RESP) && cap_port;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with READ_LAT=1, one with READ_LAT=3.
// Contention expectations follow DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        a_req0 = 0, a_req1 = 0, a_we0 = 0, a_we1 = 0;
  logic [6:0]  a_addr0 = '0, a_addr1 = '0;
  logic [31:0] a_wdata0 = '0, a_wdata1 = '0, a_rdm = '0;
  logic        a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_busy, a_cen, a_wen, a_oen;
  logic [31:0] a_rdata, a_d2m;
  logic [6:0]  a_a;

  logic        b_req0 = 0, b_req1 = 0, b_we0 = 0, b_we1 = 0;
  logic [6:0]  b_addr0 = '0, b_addr1 = '0;
  logic [31:0] b_wdata0 = '0, b_wdata1 = '0, b_rdm = '0;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_busy, b_cen, b_wen, b_oen;
  logic [31:0] b_rdata, b_d2m;
  logic [6:0]  b_a;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .req0(a_req0), .req1(a_req1), .we0(a_we0), .we1(a_we1),
    .addr0(a_addr0), .addr1(a_addr1), .wdata0(a_wdata0), .wdata1(a_wdata1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
    .rdata(a_rdata), .busy(a_busy), .CEN(a_cen), .WEN(a_wen), .OEN(a_oen),
    .A(a_a), .Data2Mem(a_d2m), .ReadDataMem(a_rdm)
  );

  dmem_arbiter #(.ADDR_W(7), .DATA_W(32), .READ_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata(b_rdata), .busy(b_busy), .CEN(b_cen), .WEN(b_wen), .OEN(b_oen),
    .A(b_a), .Data2Mem(b_d2m), .ReadDataMem(b_rdm)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are read on the falling edge.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    int grants[4];
    int exp_grants[4];
    int ng;

`ifdef DMEM_ARB_RR_EN
    exp_grants = '{0, 1, 0, 1};
`else
    exp_grants = '{0, 0, 0, 0};
`endif

    $display("[TB] start");

    // Reset
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    sample();
    check_output("rst_cen", a_cen, 1);
    check_output("rst_wen", a_wen, 1);
    check_output("rst_oen", a_oen, 1);
    check_output("rst_busy", a_busy, 0);
    check_output("rst_pulses", {a_gnt0, a_gnt1, a_rvalid0, a_rvalid1}, 0);
    check_output("rst_a", a_a, 0);
    check_output("rst_d2m", a_d2m, 0);
    check_output("rst_rdata", a_rdata, 0);

    // Port 0 write
    apply_stimulus();
    a_req0 = 1; a_we0 = 1; a_addr0 = 7'h05; a_wdata0 = 32'hDEADBEEF;
    sample();
    check_output("wr_c0_gnt0", a_gnt0, 0);
    check_output("wr_c0_cen", a_cen, 1);
    apply_stimulus();
    sample();
    check_output("wr_c1_gnt0", a_gnt0, 1);
    check_output("wr_c1_gnt1", a_gnt1, 0);
    check_output("wr_c1_cen", a_cen, 0);
    check_output("wr_c1_wen", a_wen, 0);
    check_output("wr_c1_oen", a_oen, 1);
    check_output("wr_c1_a", a_a, 32'h05);
    check_output("wr_c1_d2m", a_d2m, 32'hDEADBEEF);
    apply_stimulus();
    a_req0 = 0;
    sample();
    check_output("wr_c2_strobes", {a_cen, a_wen, a_oen}, 3'b111);
    check_output("wr_c2_busy", a_busy, 0);
    check_output("wr_c2_a_hold", a_a, 32'h05);

    // Port 1 read, READ_LAT=1
    apply_stimulus();
    a_req1 = 1; a_we1 = 0; a_addr1 = 7'h05; a_rdm = 32'h11111111;
    sample();
    apply_stimulus();
    a_rdm = 32'h12345678;
    sample();
    check_output("rd_c1_gnt1", a_gnt1, 1);
    check_output("rd_c1_gnt0", a_gnt0, 0);
    check_output("rd_c1_strobes", {a_cen, a_wen, a_oen}, 3'b010);
    check_output("rd_c1_a", a_a, 32'h05);
    apply_stimulus();
    a_req1 = 0; a_rdm = 32'hDEADBEEF;
    sample();
    check_output("rd_c2_oen", a_oen, 0);
    check_output("rd_c2_cen", a_cen, 0);
    check_output("rd_c2_rvalid1", a_rvalid1, 0);
    apply_stimulus();
    a_rdm = 32'hCAFEF00D;
    sample();
    check_output("rd_c3_rvalid1", a_rvalid1, 1);
    check_output("rd_c3_rvalid0", a_rvalid0, 0);
    check_output("rd_c3_rdata", a_rdata, 32'hDEADBEEF);
    check_output("rd_c3_strobes", {a_cen, a_wen, a_oen}, 3'b111);
    apply_stimulus();
    sample();
    check_output("rd_c4_rvalid1", a_rvalid1, 0);
    check_output("rd_c4_rdata_hold", a_rdata, 32'hDEADBEEF);
    check_output("rd_c4_busy", a_busy, 0);

    // Contention: both ports hold write requests for four grants
    apply_stimulus();
    a_req0 = 1; a_we0 = 1; a_addr0 = 7'h01; a_wdata0 = 32'h0000AAAA;
    a_req1 = 1; a_we1 = 1; a_addr1 = 7'h02; a_wdata1 = 32'h0000BBBB;
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      sample();
      if (a_gnt0 || a_gnt1) begin
        grants[ng] = a_gnt1 ? 1 : 0;
        ng++;
      end
    end
    check_output("arb_grant_count", ng, 4);
    for (int i = 0; i < ng; i++) begin
      check_output($sformatf("arb_grant_%0d", i), grants[i], exp_grants[i]);
    end
    a_req0 = 0;
    apply_stimulus();
    sample();
    check_output("arb_idle_gnt1", a_gnt1, 0);
    apply_stimulus();
    sample();
    check_output("arb_solo_gnt1", a_gnt1, 1);
    check_output("arb_solo_a", a_a, 32'h02);
    apply_stimulus();
    a_req1 = 0;

    // Reset while a read is waiting
    apply_stimulus();
    a_req0 = 1; a_we0 = 0; a_addr0 = 7'h09;
    sample();
    apply_stimulus();
    sample();
    check_output("rrst_gnt0", a_gnt0, 1);
    apply_stimulus();
    a_req0 = 0; rst = 1;
    sample();
    check_output("rrst_wait_oen", a_oen, 0);
    apply_stimulus();
    rst = 0;
    sample();
    check_output("rrst_busy", a_busy, 0);
    check_output("rrst_strobes", {a_cen, a_wen, a_oen}, 3'b111);
    check_output("rrst_rvalid0", a_rvalid0, 0);
    check_output("rrst_rdata", a_rdata, 0);
    check_output("rrst_a", a_a, 0);
    apply_stimulus();
    sample();
    check_output("rrst_no_late_rvalid", {a_rvalid0, a_rvalid1}, 0);

    // Fresh read after the reset
    apply_stimulus();
    a_req0 = 1; a_we0 = 0; a_addr0 = 7'h03; a_rdm = 32'h0;
    sample();
    apply_stimulus();
    sample();
    check_output("post_gnt0", a_gnt0, 1);
    check_output("post_a", a_a, 32'h03);
    apply_stimulus();
    a_req0 = 0; a_rdm = 32'hA5A5A5A5;
    sample();
    apply_stimulus();
    a_rdm = 32'h0;
    sample();
    check_output("post_rvalid0", a_rvalid0, 1);
    check_output("post_rdata", a_rdata, 32'hA5A5A5A5);

    // READ_LAT=3 read on the second instance, top address
    apply_stimulus();
    b_req0 = 1; b_we0 = 0; b_addr0 = 7'h7F; b_rdm = 32'h0;
    sample();
    apply_stimulus();
    b_rdm = 32'h1;
    sample();
    check_output("lat3_gnt0", b_gnt0, 1);
    check_output("lat3_a", b_a, 32'h7F);
    apply_stimulus();
    b_req0 = 0; b_addr0 = 7'h00; b_rdm = 32'h2;
    sample();
    check_output("lat3_c2_oen", b_oen, 0);
    apply_stimulus();
    b_rdm = 32'h3;
    sample();
    check_output("lat3_c3_a_frozen", b_a, 32'h7F);
    check_output("lat3_c3_rvalid0", b_rvalid0, 0);
    apply_stimulus();
    b_rdm = 32'h44444444;
    sample();
    check_output("lat3_c4_oen", b_oen, 0);
    check_output("lat3_c4_rvalid0", b_rvalid0, 0);
    apply_stimulus();
    b_rdm = 32'h5;
    sample();
    check_output("lat3_c5_rvalid0", b_rvalid0, 1);
    check_output("lat3_c5_rdata", b_rdata, 32'h44444444);
    check_output("lat3_c5_strobes", {b_cen, b_wen, b_oen}, 3'b111);
    apply_stimulus();
    sample();
    check_output("lat3_c6_busy", b_busy, 0);
    check_output("lat3_c6_rdata_hold", b_rdata, 32'h44444444);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
